// File: rtl/msp430_bb_pkg.sv
// Shared types and helpers for the blackbone external-port arbiter.
package msp430_bb_pkg;

  localparam int NUM_REQ_MIN   = 2;
  localparam int NUM_REQ_MAX   = 16;
  localparam int READ_LAT_MIN  = 1;
  localparam int READ_LAT_MAX  = 4;
  localparam int MAX_BURST_MIN = 1;
  localparam int MAX_BURST_MAX = 255;

  localparam int IDX_W  = $clog2(NUM_REQ_MAX);
  localparam int BCNT_W = 8;

  typedef logic [IDX_W:0] cnt_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  function automatic int id_w(input int n);
    return (n <= NUM_REQ_MIN) ? 1 : $clog2(n);
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // First set bit of req at or above ptr, wrapping at n. Scanning the offsets
  // downward lets the smallest offset overwrite the result last.
  function automatic pick_t rr_pick(input logic [NUM_REQ_MAX-1:0] req,
                                    input logic [IDX_W-1:0]       ptr,
                                    input cnt_t                   n);
    pick_t p;
    cnt_t  k;
    p = '0;
    for (int off = NUM_REQ_MAX - 1; off >= 0; off--) begin
      k = cnt_t'(ptr) + cnt_t'(off);
      if (k >= n) k = k - n;
      if ((cnt_t'(off) < n) && req[k[IDX_W-1:0]]) begin
        p.found = 1'b1;
        p.idx   = k[IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/msp430_bb_rr_arbiter.sv
// Combinational round-robin picker with the rotating pointer and the
// burst-lock counter that lets one requester keep the bus for a bounded run.
module msp430_bb_rr_arbiter
  import msp430_bb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  parameter int ID_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] lock_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    win_o,
  output logic               found_o
);
  localparam int                MB        = clamp(MAX_BURST, MAX_BURST_MIN, MAX_BURST_MAX);
  localparam logic [BCNT_W-1:0] BURST_LIM = BCNT_W'(MB - 1);

  logic [NUM_REQ_MAX-1:0] req_ext;
  pick_t                  pick;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d, bcnt_eff;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req_i;
    pick                   = rr_pick(req_ext, IDX_W'(ptr_q), cnt_t'(NUM_REQ));
    win_o                  = ID_W'(pick.idx);
    found_o                = pick.found;
    gnt_o                  = '0;
    // A locked owner that withdraws its request forfeits the rest of its burst.
    bcnt_eff               = req_i[ptr_q] ? bcnt_q : '0;
    ptr_d                  = ptr_q;
    bcnt_d                 = bcnt_eff;
    if (pick.found) begin
      gnt_o[win_o] = 1'b1;
      if (lock_i[win_o] && (bcnt_eff < BURST_LIM)) begin
        ptr_d  = win_o;
        bcnt_d = bcnt_eff + BCNT_W'(1);
      end else begin
        ptr_d  = (win_o == ID_W'(NUM_REQ - 1)) ? '0 : win_o + ID_W'(1);
        bcnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q  <= '0;
      bcnt_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      bcnt_q <= bcnt_d;
    end
  end

endmodule

// File: rtl/msp430_bb_arbiter.sv
// Blackbone external-port arbiter: round-robin grant, registered issue stage and
// an in-order read-return pipeline routing bb_ext_dout_i back to its requester.
module msp430_bb_arbiter
  import msp430_bb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        lock_i,
  input  logic [NUM_REQ*AW-1:0]     addr_i,
  input  logic [NUM_REQ*DW-1:0]     din_i,
  input  logic [NUM_REQ*(DW/8)-1:0] we_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DW-1:0]             rdata_o,
  output logic                      busy_o,
  output logic [AW-1:0]             bb_ext_addr_o,
  output logic [DW-1:0]             bb_ext_din_o,
  output logic                      bb_ext_en_o,
  output logic [DW/8-1:0]           bb_ext_we_o,
  input  logic [DW-1:0]             bb_ext_dout_i
);
  localparam int BW    = DW / 8;
  localparam int ID_W  = id_w(NUM_REQ);
  localparam int RL    = clamp(READ_LATENCY, READ_LAT_MIN, READ_LAT_MAX);
  localparam int DEPTH = RL + 1;

  logic [AW-1:0] addr_a [NUM_REQ];
  logic [DW-1:0] din_a  [NUM_REQ];
  logic [BW-1:0] we_a   [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_a[gi] = addr_i[gi*AW +: AW];
    assign din_a[gi]  = din_i[gi*DW +: DW];
    assign we_a[gi]   = we_i[gi*BW +: BW];
  end

  logic [ID_W-1:0] win;
  logic            found;
  logic            issue_rd;

  msp430_bb_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST),
    .ID_W      (ID_W)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .lock_i  (lock_i),
    .gnt_o   (gnt_o),
    .win_o   (win),
    .found_o (found)
  );

  assign issue_rd = found && (we_a[win] == '0);

  logic          en_q;
  logic [BW-1:0] we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;

  // Address and data keep their last value in idle cycles; only the strobes drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= 1'b0;
      we_q   <= '0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      en_q <= found;
      if (found) begin
        we_q   <= we_a[win];
        addr_q <= addr_a[win];
        din_q  <= din_a[win];
      end else begin
        we_q <= '0;
      end
    end
  end

  // Stage k holds the read issued on the bus k cycles ago; stage RL is the
  // cycle in which the memory drives its data.
  logic [DEPTH-1:0]           pv_q;
  logic [DEPTH-1:0][ID_W-1:0] pid_q;
  logic [NUM_REQ-1:0]         rvalid_q;
  logic [DW-1:0]              rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv_q     <= '0;
      pid_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      pv_q     <= {pv_q[DEPTH-2:0], issue_rd};
      pid_q    <= {pid_q[DEPTH-2:0], win};
      rvalid_q <= pv_q[RL] ? (NUM_REQ'(1) << pid_q[RL]) : '0;
      if (pv_q[RL]) rdata_q <= bb_ext_dout_i;
    end
  end

  assign bb_ext_en_o   = en_q;
  assign bb_ext_we_o   = we_q;
  assign bb_ext_addr_o = addr_q;
  assign bb_ext_din_o  = din_q;
  assign rvalid_o      = rvalid_q;
  assign rdata_o       = rdata_q;
  assign busy_o        = |pv_q;

endmodule
